uart_apb_sequencer: RTL and testbench

APB master that owns one CoreUARTapb instance: after reset it programs the baud/mode control registers, then continuously polls the status register. It moves bytes between two valid/ready byte streams and the UART's TX/RX data registers. It replaces BFM-driven register traffic when the UART runs inside the fabric without a processor.

---
 rtl/uart_apb_pkg.sv | 19 +
 rtl/apb_master_xfer.sv | 64 ++++++
 rtl/uart_apb_sequencer.sv | 93 +++++++++
 tb/tb_uart_apb_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: register map, status/error bit indices and sequencer states for uart_apb_sequencer
package uart_apb_pkg;
  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1 = 5'h08;
  localparam logic [4:0] ADDR_CTRL2 = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam int ST_TXRDY = 0;
  localparam int ST_RXRDY = 1;
  localparam int ST_PARITY = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_FRAMING = 4;
  localparam int ERR_PARITY = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_FRAMING = 2;
  localparam int ERR_SLVERR = 3;
  localparam int ERR_TIMEOUT = 4;
  typedef enum logic [2:0] {INIT_C1, INIT_C2, POLL, RD_RX, WR_TX} state_e;
endpackage

// File: rtl/apb_master_xfer.sv
// apb_master_xfer: single APB transfer engine with setup/access sequencing and access timeout
module apb_master_xfer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [4:0] addr,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [4:0] paddr,
  output logic [7:0] pwdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic       timeout
);
  logic       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d, start;
  logic [4:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d, cnt_q, cnt_d;
  // a request is only taken while idle, so every transfer is preceded by at least one idle cycle
  always_comb begin
    done = penable_q && pready;
    timeout = penable_q && !pready && cnt_q == TIMEOUT - 8'd1;
    slverr = done && pslverr;
    rdata = prdata;
    start = !psel_q && req;
    psel_d = start || (psel_q && !done && !timeout);
    penable_d = psel_q && !done && !timeout;
    pwrite_d = start ? wr : pwrite_q;
    paddr_d = start ? addr : paddr_q;
    pwdata_d = start ? wdata : pwdata_q;
    cnt_d = penable_q ? cnt_q + 8'd1 : 8'd0;
  end
  // bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      cnt_q <= '0;
    end else begin
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q <= cnt_d;
    end
  end
  assign psel = psel_q;
  assign penable = penable_q;
  assign pwrite = pwrite_q;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
endmodule

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master that programs a CoreUARTapb and shuttles bytes between streams and its data registers
module uart_apb_sequencer
  import uart_apb_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter int          PRG_BIT8 = 1,
  parameter int          PRG_PARITY = 0,
  parameter int          FIXEDMODE = 0,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  output logic [4:0] err_flags,
  input  logic       err_clr
);
  localparam logic [7:0] CTRL2_VAL = {BAUD_VALUE[12:8], PRG_PARITY == 2, PRG_PARITY != 0, PRG_BIT8 != 0};
  state_e     state_q, state_d, poll_nxt;
  logic [1:0] status_q, status_d;
  logic [7:0] rx_data_q, rx_data_d, rdata, wdata;
  logic [4:0] err_q, err_d, new_err, addr;
  logic       fin_q, fin_d, rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d, init_done_q, init_done_d;
  logic       done, slverr, timeout, wr, poll_done;
  apb_master_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk(PCLK), .rst(PRESET), .req(1'b1), .addr(addr), .wr(wr), .wdata(wdata),
    .prdata(PRDATA), .pready(PREADY), .pslverr(PSLVERR),
    .psel(PSEL), .penable(PENABLE), .pwrite(PWRITE), .paddr(PADDR), .pwdata(PWDATA),
    .done(done), .rdata(rdata), .slverr(slverr), .timeout(timeout)
  );
  // state advances only in the idle cycle after a completed transfer; a timeout leaves it put so the transfer is retried
  always_comb begin
    poll_done = done && state_q == POLL;
    poll_nxt = (status_q[ST_RXRDY] && !rx_valid_q) ? RD_RX : (status_q[ST_TXRDY] && tx_valid) ? WR_TX : POLL;
    state_d = !fin_q ? state_q : state_q == INIT_C1 ? INIT_C2 : state_q == POLL ? poll_nxt : POLL;
    fin_d = done;
    status_d = poll_done ? rdata[1:0] : status_q;
    rx_data_d = (done && state_q == RD_RX) ? rdata : rx_data_q;
    rx_valid_d = (rx_valid_q && !rx_ready) || (done && state_q == RD_RX);
    tx_ready_d = done && state_q == WR_TX;
    init_done_d = init_done_q || FIXEDMODE != 0 || (done && state_q == INIT_C2);
    new_err = '0;
    new_err[ERR_PARITY] = poll_done && rdata[ST_PARITY];
    new_err[ERR_OVERFLOW] = poll_done && rdata[ST_OVERFLOW];
    new_err[ERR_FRAMING] = poll_done && rdata[ST_FRAMING];
    new_err[ERR_SLVERR] = slverr;
    new_err[ERR_TIMEOUT] = timeout;
    err_d = (err_clr ? 5'd0 : err_q) | new_err;
    addr = state_d == INIT_C1 ? ADDR_CTRL1 : state_d == INIT_C2 ? ADDR_CTRL2 : state_d == RD_RX ? ADDR_RXDATA : state_d == WR_TX ? ADDR_TXDATA : ADDR_STATUS;
    wr = state_d inside {INIT_C1, INIT_C2, WR_TX};
    wdata = state_d == INIT_C1 ? BAUD_VALUE[7:0] : state_d == INIT_C2 ? CTRL2_VAL : state_d == WR_TX ? tx_data : 8'd0;
  end
  // sequencer and stream registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= FIXEDMODE != 0 ? POLL : INIT_C1;
      status_q <= '0;
      fin_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      fin_q <= fin_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      init_done_q <= init_done_d;
      err_q <= err_d;
    end
  end
  assign tx_ready = tx_ready_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign init_done = init_done_q;
  assign err_flags = err_q;
endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: directed self-checking bench with a simple APB slave model
module tb_uart_apb_sequencer;
  logic       PCLK = 1'b0, PRESET = 1'b1;
  logic [4:0] PADDR;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0] PWDATA, PRDATA;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, init_done, err_clr;
  logic [4:0] err_flags;
  logic       stall = 1'b0, pslv = 1'b0;
  logic [7:0] status_v = 8'h00, rxd_v = 8'h00;
  int         checks = 0, errors = 0, tx_cnt = 0, n;

  uart_apb_sequencer #(.BAUD_VALUE(13'h1A3), .PRG_BIT8(1), .PRG_PARITY(2), .FIXEDMODE(0), .TIMEOUT(8'd255)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done), .err_flags(err_flags), .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;
  assign PREADY = !stall;
  assign PSLVERR = pslv;
  assign PRDATA = PADDR == 5'h10 ? status_v : PADDR == 5'h04 ? rxd_v : 8'h00;
  always @(posedge PCLK) if (tx_ready) tx_cnt <= tx_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [4:0] ea, input logic ew, input logic [7:0] ed);
    int k = 0;
    @(negedge PCLK);
    while (!(PSEL && PENABLE && PREADY) && k < 1000) begin
      @(negedge PCLK);
      k++;
    end
    chk({tag, "_done"}, 32'(k < 1000), 1);
    chk({tag, "_addr"}, 32'(PADDR), 32'(ea));
    chk({tag, "_wr"}, 32'(PWRITE), 32'(ew));
    if (ew) chk({tag, "_wdata"}, 32'(PWDATA), 32'(ed));
    @(negedge PCLK);
  endtask

  initial begin
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 0); chk("rst_penable", PENABLE, 0); chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0); chk("rst_pwdata", PWDATA, 0); chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0); chk("rst_rx_data", rx_data, 0);
    chk("rst_init_done", init_done, 0); chk("rst_err", err_flags, 0);
    PRESET = 1'b0;
    xfer("ctrl1", 5'h08, 1'b1, 8'hA3);
    chk("init_early", init_done, 0);
    xfer("ctrl2", 5'h0C, 1'b1, 8'h0F);
    chk("init_done", init_done, 1);
    xfer("status0", 5'h10, 1'b0, 8'h00);
    status_v = 8'h01; tx_valid = 1'b1; tx_data = 8'h5A;
    xfer("status1", 5'h10, 1'b0, 8'h00);
    chk("gap_psel", PSEL, 0);
    @(negedge PCLK);
    chk("setup_psel", PSEL, 1); chk("setup_penable", PENABLE, 0); chk("setup_paddr", PADDR, 5'h00);
    xfer("tx5a", 5'h00, 1'b1, 8'h5A);
    chk("tx_ready_pulse", tx_ready, 1);
    tx_data = 8'h77; status_v = 8'h03; rxd_v = 8'hC3;
    @(negedge PCLK);
    chk("tx_ready_once", tx_ready, 0); chk("tx_cnt1", tx_cnt, 1);
    xfer("status3", 5'h10, 1'b0, 8'h00);
    xfer("rx_first", 5'h04, 1'b0, 8'h00);
    chk("rx_valid", rx_valid, 1); chk("rx_data", rx_data, 8'hC3);
    xfer("status3b", 5'h10, 1'b0, 8'h00);
    xfer("tx77", 5'h00, 1'b1, 8'h77);
    tx_valid = 1'b0; status_v = 8'h02;
    for (int i = 0; i < 4; i++) xfer("rx_defer", 5'h10, 1'b0, 8'h00);
    chk("rx_held", rx_valid, 1); chk("tx_cnt2", tx_cnt, 2);
    rxd_v = 8'h3C; rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    chk("rx_consumed", rx_valid, 0);
    xfer("status2", 5'h10, 1'b0, 8'h00);
    xfer("rx_second", 5'h04, 1'b0, 8'h00);
    chk("rx_data2", rx_data, 8'h3C);
    rx_ready = 1'b1; status_v = 8'h00;
    @(negedge PCLK);
    rx_ready = 1'b0;
    xfer("status00", 5'h10, 1'b0, 8'h00);
    stall = 1'b1;
    @(negedge PCLK);
    chk("to_setup", PSEL && !PENABLE, 1);
    n = 0;
    @(negedge PCLK);
    while (PENABLE && n < 400) begin
      n++;
      @(negedge PCLK);
    end
    chk("timeout_len", n, 255); chk("timeout_psel", PSEL, 0); chk("timeout_flag", err_flags, 5'b10000);
    @(negedge PCLK);
    chk("retry_psel", PSEL, 1); chk("retry_paddr", PADDR, 5'h10);
    repeat (40) @(negedge PCLK);
    stall = 1'b0;
    xfer("retry_done", 5'h10, 1'b0, 8'h00);
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    chk("err_clr", err_flags, 0);
    status_v = 8'h1C; pslv = 1'b1;
    xfer("status_err", 5'h10, 1'b0, 8'h00);
    chk("err_all", err_flags, 5'b01111);
    pslv = 1'b0; status_v = 8'h01; tx_valid = 1'b1; tx_data = 8'h99;
    xfer("status_tx", 5'h10, 1'b0, 8'h00);
    @(negedge PCLK);
    chk("tx_setup_psel", PSEL, 1); chk("tx_setup_paddr", PADDR, 5'h00); chk("tx_setup_pwrite", PWRITE, 1);
    stall = 1'b1;
    @(negedge PCLK);
    chk("tx_access", PENABLE, 1); chk("tx_pwdata", PWDATA, 8'h99);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("mid_rst_psel", PSEL, 0); chk("mid_rst_penable", PENABLE, 0); chk("mid_rst_tx_ready", tx_ready, 0);
    chk("mid_rst_err", err_flags, 0); chk("mid_rst_init", init_done, 0);
    PRESET = 1'b0; stall = 1'b0;
    xfer("ctrl1_again", 5'h08, 1'b1, 8'hA3);
    chk("tx_cnt_final", tx_cnt, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
